// File: rtl/hwpf_pkg.sv
// Shared types and helpers for the next-line prefetch request scheduler.
// Holds the scheduler state encoding, the TID width and the prefetch TID range check.
package hwpf_pkg;

   localparam int unsigned HWPF_TID_W = 7;

   typedef logic [HWPF_TID_W-1:0] hwpf_tid_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND_CPU = 2'd1,
      ST_PF_WAIT  = 2'd2,
      ST_SEND_PF  = 2'd3
   } hwpf_sched_state_t;

   // Default request payload carried between CPU, prefetch FIFO and dcache.
   typedef struct packed {
      logic [47:0] addr;
      logic [2:0]  size;
      logic [3:0]  op;
      logic [7:0]  be;
   } req_cpu_dcache_t;

   function automatic logic hwpf_is_pf_tid(input hwpf_tid_t   tid,
                                           input hwpf_tid_t   base,
                                           input int unsigned num);
      int unsigned t;
      int unsigned b;
      t = {25'd0, tid};
      b = {25'd0, base};
      return (t >= b) && (t < (b + num));
   endfunction

endpackage

// File: rtl/hwpf_tid_alloc.sv
// Prefetch TID slot allocator: busy bitmap, lowest-free-slot encoder and a
// registered count of outstanding slots.
module hwpf_tid_alloc #(
   parameter int unsigned  NUM_SLOTS = 4,
   localparam int unsigned IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
   localparam int unsigned CNT_W     = $clog2(NUM_SLOTS + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             alloc_i,
   input  logic [IDX_W-1:0] alloc_idx_i,
   input  logic             free_i,
   input  logic [IDX_W-1:0] free_idx_i,
   output logic             free_avail_o,
   output logic [IDX_W-1:0] free_idx_o,
   output logic [CNT_W-1:0] count_o
);

   logic [NUM_SLOTS-1:0] busy_q;
   logic [NUM_SLOTS-1:0] busy_d;
   logic [CNT_W-1:0]     count_q;
   logic [CNT_W-1:0]     count_d;

   // Scanning downwards leaves the lowest free index as the final winner.
   always_comb begin
      free_avail_o = 1'b0;
      free_idx_o   = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_avail_o = 1'b1;
            free_idx_o   = IDX_W'(i);
         end
      end
   end

   // Free and allocate never collide: the allocated slot was free in busy_q.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (free_i && (free_idx_i == IDX_W'(i))) begin
            busy_d[i] = 1'b0;
         end
         if (alloc_i && (alloc_idx_i == IDX_W'(i))) begin
            busy_d[i] = 1'b1;
         end
      end
   end

   always_comb begin
      count_d = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         count_d = count_d + CNT_W'(busy_d[i]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/hwpf_nl_req_sched.sv
// Arbitrates demand requests and next-line prefetches onto the HPDcache request port,
// with demand priority, a post-demand backoff window and a bounded prefetch TID pool.
module hwpf_nl_req_sched
   import hwpf_pkg::*;
#(
   parameter type                   cpu_addr_t      = req_cpu_dcache_t,
   parameter int unsigned           MAX_PF_INFLIGHT = 4,
   parameter logic [HWPF_TID_W-1:0] PF_TID_BASE     = 7'h70,
   parameter int unsigned           BACKOFF_CYCLES  = 2,
   localparam int unsigned          IDX_W = (MAX_PF_INFLIGHT > 1) ? $clog2(MAX_PF_INFLIGHT) : 1,
   localparam int unsigned          CNT_W = $clog2(MAX_PF_INFLIGHT + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  pf_enable_i,
   input  logic                  cpu_req_valid_i,
   input  cpu_addr_t             cpu_req_i,
   input  logic [HWPF_TID_W-1:0] cpu_req_tid_i,
   output logic                  cpu_req_ready_o,
   output logic                  pf_read_o,
   input  logic                  pf_req_valid_i,
   input  cpu_addr_t             pf_req_i,
   output logic                  dc_req_valid_o,
   output cpu_addr_t             dc_req_o,
   output logic [HWPF_TID_W-1:0] dc_req_tid_o,
   output logic                  dc_req_is_pf_o,
   input  logic                  dc_req_ready_i,
   input  logic                  dc_rsp_valid_i,
   input  logic [HWPF_TID_W-1:0] dc_rsp_tid_i,
   output logic [CNT_W-1:0]      pf_inflight_o
);

   localparam int unsigned BO_W = 4;

   hwpf_sched_state_t     state_q,   state_d;
   cpu_addr_t             payload_q, payload_d;
   logic [HWPF_TID_W-1:0] tid_q,     tid_d;
   logic [IDX_W-1:0]      slot_q,    slot_d;
   logic [BO_W-1:0]       backoff_q, backoff_d;
   logic                  valid_q,   valid_d;
   logic                  is_pf_q,   is_pf_d;

   logic                  alloc;
   logic                  free_avail;
   logic [IDX_W-1:0]      free_idx;
   logic                  rsp_free;
   logic [IDX_W-1:0]      rsp_idx;
   logic [CNT_W-1:0]      inflight;

   assign rsp_free = dc_rsp_valid_i && hwpf_is_pf_tid(dc_rsp_tid_i, PF_TID_BASE, MAX_PF_INFLIGHT);
   assign rsp_idx  = IDX_W'(dc_rsp_tid_i - PF_TID_BASE);

   hwpf_tid_alloc #(
      .NUM_SLOTS (MAX_PF_INFLIGHT)
   ) u_tid_alloc (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .alloc_i      (alloc),
      .alloc_idx_i  (slot_q),
      .free_i       (rsp_free),
      .free_idx_i   (rsp_idx),
      .free_avail_o (free_avail),
      .free_idx_o   (free_idx),
      .count_o      (inflight)
   );

   // A prefetch slot is only marked busy once the dcache has actually taken it.
   always_comb begin
      state_d         = state_q;
      payload_d       = payload_q;
      tid_d           = tid_q;
      slot_d          = slot_q;
      pf_read_o       = 1'b0;
      cpu_req_ready_o = 1'b0;
      alloc           = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cpu_req_ready_o = 1'b1;
            if (cpu_req_valid_i) begin
               payload_d = cpu_req_i;
               tid_d     = cpu_req_tid_i;
               state_d   = ST_SEND_CPU;
            end else if (pf_enable_i && (backoff_q == '0) && free_avail && !flush_i) begin
               pf_read_o = 1'b1;
               state_d   = ST_PF_WAIT;
            end
         end
         ST_PF_WAIT: begin
            if (pf_req_valid_i && !flush_i) begin
               payload_d = pf_req_i;
               tid_d     = PF_TID_BASE + HWPF_TID_W'(free_idx);
               slot_d    = free_idx;
               state_d   = ST_SEND_PF;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND_CPU: begin
            if (dc_req_ready_i) begin
               cpu_req_ready_o = 1'b1;
               if (cpu_req_valid_i) begin
                  payload_d = cpu_req_i;
                  tid_d     = cpu_req_tid_i;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_SEND_PF: begin
            if (dc_req_ready_i) begin
               alloc   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      backoff_d = backoff_q;
      if (cpu_req_valid_i && cpu_req_ready_o) begin
         backoff_d = BO_W'(BACKOFF_CYCLES);
      end else if (backoff_q != '0) begin
         backoff_d = backoff_q - BO_W'(1);
      end
   end

   assign valid_d = (state_d == ST_SEND_CPU) || (state_d == ST_SEND_PF);
   assign is_pf_d = (state_d == ST_SEND_PF);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         payload_q <= '0;
         tid_q     <= '0;
         slot_q    <= '0;
         backoff_q <= '0;
         valid_q   <= 1'b0;
         is_pf_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         payload_q <= payload_d;
         tid_q     <= tid_d;
         slot_q    <= slot_d;
         backoff_q <= backoff_d;
         valid_q   <= valid_d;
         is_pf_q   <= is_pf_d;
      end
   end

   assign dc_req_valid_o = valid_q;
   assign dc_req_is_pf_o = is_pf_q;
   assign dc_req_o       = payload_q;
   assign dc_req_tid_o   = tid_q;
   assign pf_inflight_o  = inflight;

endmodule

// File: tb/tb_hwpf_nl_req_sched.sv
// Self-checking bench for hwpf_nl_req_sched: a FIFO model feeds prefetches, a scoreboard
// of expected dcache requests is compared on every dcache handshake.
module tb_hwpf_nl_req_sched;
   import hwpf_pkg::*;

   typedef req_cpu_dcache_t pay_t;

   typedef struct {
      pay_t       pay;
      logic [6:0] tid;
      logic       is_pf;
   } exp_t;

   logic       clk_i;
   logic       rst_ni;
   logic       flush_i;
   logic       pf_enable_i;
   logic       cpu_req_valid_i;
   pay_t       cpu_req_i;
   logic [6:0] cpu_req_tid_i;
   logic       cpu_req_ready_o;
   logic       pf_read_o;
   logic       pf_req_valid_i;
   pay_t       pf_req_i;
   logic       dc_req_valid_o;
   pay_t       dc_req_o;
   logic [6:0] dc_req_tid_o;
   logic       dc_req_is_pf_o;
   logic       dc_req_ready_i;
   logic       dc_rsp_valid_i;
   logic [6:0] dc_rsp_tid_i;
   logic [2:0] pf_inflight_o;

   int   tests_run;
   int   tests_failed;
   int   pop_count;
   int   hs_count;
   exp_t exp_q[$];
   pay_t fifo_q[$];
   bit   fifo_rd;
   bit   stalled;
   pay_t hold_pay;
   logic [6:0] hold_tid;
   logic hold_pf;

   hwpf_nl_req_sched dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .flush_i         (flush_i),
      .pf_enable_i     (pf_enable_i),
      .cpu_req_valid_i (cpu_req_valid_i),
      .cpu_req_i       (cpu_req_i),
      .cpu_req_tid_i   (cpu_req_tid_i),
      .cpu_req_ready_o (cpu_req_ready_o),
      .pf_read_o       (pf_read_o),
      .pf_req_valid_i  (pf_req_valid_i),
      .pf_req_i        (pf_req_i),
      .dc_req_valid_o  (dc_req_valid_o),
      .dc_req_o        (dc_req_o),
      .dc_req_tid_o    (dc_req_tid_o),
      .dc_req_is_pf_o  (dc_req_is_pf_o),
      .dc_req_ready_i  (dc_req_ready_i),
      .dc_rsp_valid_i  (dc_rsp_valid_i),
      .dc_rsp_tid_i    (dc_rsp_tid_i),
      .pf_inflight_o   (pf_inflight_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // FIFO model: a pop seen in one cycle presents the head entry in the next cycle.
   always begin
      @(negedge clk_i);
      fifo_rd = (rst_ni === 1'b1) && (pf_read_o === 1'b1);
      if (fifo_rd) pop_count++;
      @(posedge clk_i);
      #1;
      if (fifo_rd && fifo_q.size() > 0) begin
         pf_req_valid_i = 1'b1;
         pf_req_i       = fifo_q.pop_front();
      end else begin
         pf_req_valid_i = 1'b0;
         pf_req_i       = '0;
      end
   end

   // Scoreboard monitor: every dcache handshake must match the next expected request,
   // and a stalled request must hold valid, payload and TID.
   always @(negedge clk_i) begin
      exp_t e;
      if (rst_ni !== 1'b1) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            tests_run++;
            if (dc_req_valid_o !== 1'b1 || dc_req_o !== hold_pay || dc_req_tid_o !== hold_tid || dc_req_is_pf_o !== hold_pf) begin
               tests_failed++;
               $display("[TB] FAIL hold_stable: got valid=%b tid=%h pay=%h pf=%b, required valid=1 tid=%h pay=%h pf=%b",
                        dc_req_valid_o, dc_req_tid_o, dc_req_o, dc_req_is_pf_o, hold_tid, hold_pay, hold_pf);
            end
         end
         if (dc_req_valid_o === 1'b1 && dc_req_ready_i === 1'b1) begin
            hs_count++;
            tests_run++;
            stalled = 1'b0;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("[TB] FAIL dc_req_unexpected: got tid=%h pay=%h pf=%b, required no request", dc_req_tid_o, dc_req_o, dc_req_is_pf_o);
            end else begin
               e = exp_q.pop_front();
               if (dc_req_o !== e.pay || dc_req_tid_o !== e.tid || dc_req_is_pf_o !== e.is_pf) begin
                  tests_failed++;
                  $display("[TB] FAIL dc_req_scoreboard: got tid=%h pay=%h pf=%b, required tid=%h pay=%h pf=%b",
                           dc_req_tid_o, dc_req_o, dc_req_is_pf_o, e.tid, e.pay, e.is_pf);
               end
            end
         end else if (dc_req_valid_o === 1'b1) begin
            stalled  = 1'b1;
            hold_pay = dc_req_o;
            hold_tid = dc_req_tid_o;
            hold_pf  = dc_req_is_pf_o;
         end else begin
            stalled = 1'b0;
         end
      end
   end

   function automatic pay_t mk(input int n);
      pay_t p;
      p.addr = 48'h1000_0000 + (48'(n) << 6);
      p.size = 3'd3;
      p.op   = 4'(n);
      p.be   = 8'hff;
      return p;
   endfunction

   function automatic exp_t mk_exp(input pay_t p, input logic [6:0] t, input logic f);
      exp_t e;
      e.pay   = p;
      e.tid   = t;
      e.is_pf = f;
      return e;
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_i);
   endtask

   task automatic applyStimulus_idle();
      flush_i         = 1'b0;
      pf_enable_i     = 1'b0;
      cpu_req_valid_i = 1'b0;
      cpu_req_i       = '0;
      cpu_req_tid_i   = '0;
      dc_req_ready_i  = 1'b0;
      dc_rsp_valid_i  = 1'b0;
      dc_rsp_tid_i    = '0;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      applyStimulus_idle();
      fifo_q.delete();
      exp_q.delete();
      repeat (2) step();
      pop_count = 0;
      hs_count  = 0;
      rst_ni    = 1'b1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      applyStimulus_idle();
      #2;
      tests_run++;
      if (dc_req_valid_o !== 1'b0 || dc_req_is_pf_o !== 1'b0 || dc_req_tid_o !== 7'h00 || dc_req_o !== '0 ||
          pf_inflight_o !== 3'd0 || pf_read_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got valid=%b pf=%b tid=%h pay=%h inflight=%0d read=%b, required all zero",
                  dc_req_valid_o, dc_req_is_pf_o, dc_req_tid_o, dc_req_o, pf_inflight_o, pf_read_o);
      end
      do_reset();
      cpu_req_valid_i = 1'b1;
      cpu_req_i       = mk(9);
      cpu_req_tid_i   = 7'h05;
      sample();
      tests_run++;
      if (cpu_req_ready_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_idle_ready: got %b, required 1", cpu_req_ready_o);
      end
      step();
      cpu_req_valid_i = 1'b0;
      sample();
      tests_run++;
      if (dc_req_valid_o !== 1'b1 || dc_req_tid_o !== 7'h05 || dc_req_o !== mk(9)) begin
         tests_failed++;
         $display("[TB] FAIL reset_held_req: got valid=%b tid=%h, required valid=1 tid=05", dc_req_valid_o, dc_req_tid_o);
      end
      step();
      rst_ni = 1'b0;
      #1;
      tests_run++;
      if (dc_req_valid_o !== 1'b0 || dc_req_tid_o !== 7'h00 || dc_req_o !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_midop_drop: got valid=%b tid=%h pay=%h, required all zero", dc_req_valid_o, dc_req_tid_o, dc_req_o);
      end
   endtask

   task automatic test_first_prefetch();
      do_reset();
      dc_req_ready_i = 1'b1;
      fifo_q.push_back(mk(1));
      exp_q.push_back(mk_exp(mk(1), 7'h70, 1'b1));
      pf_enable_i = 1'b1;
      sample();
      tests_run++;
      if (pf_read_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL t1_pop_c0: got %b, required 1", pf_read_o);
      end
      step();
      sample();
      tests_run++;
      if (pf_read_o !== 1'b0 || dc_req_valid_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL t1_wait_c1: got read=%b valid=%b, required 0 0", pf_read_o, dc_req_valid_o);
      end
      step();
      sample();
      tests_run++;
      if (dc_req_valid_o !== 1'b1 || dc_req_tid_o !== 7'h70 || dc_req_is_pf_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL t1_req_c2: got valid=%b tid=%h pf=%b, required 1 70 1", dc_req_valid_o, dc_req_tid_o, dc_req_is_pf_o);
      end
      step();
      pf_enable_i = 1'b0;
      sample();
      tests_run++;
      if (pf_inflight_o !== 3'd1 || exp_q.size() != 0 || hs_count != 1) begin
         tests_failed++;
         $display("[TB] FAIL t1_inflight: got inflight=%0d left=%0d hs=%0d, required 1 0 1", pf_inflight_o, exp_q.size(), hs_count);
      end
   endtask

   task automatic test_demand_priority();
      int first_pop;
      first_pop = -1;
      do_reset();
      dc_req_ready_i = 1'b1;
      fifo_q.push_back(mk(2));
      pf_enable_i     = 1'b1;
      cpu_req_valid_i = 1'b1;
      cpu_req_i       = mk(20);
      cpu_req_tid_i   = 7'h05;
      exp_q.push_back(mk_exp(mk(20), 7'h05, 1'b0));
      exp_q.push_back(mk_exp(mk(2), 7'h70, 1'b1));
      sample();
      tests_run++;
      if (cpu_req_ready_o !== 1'b1 || pf_read_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL t2_priority: got ready=%b read=%b, required 1 0", cpu_req_ready_o, pf_read_o);
      end
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k == 1) cpu_req_valid_i = 1'b0;
         sample();
         if (pf_read_o === 1'b1 && first_pop < 0) first_pop = k;
      end
      pf_enable_i = 1'b0;
      tests_run++;
      if (first_pop != 3) begin
         tests_failed++;
         $display("[TB] FAIL t2_backoff_pop: got first pop at cycle %0d, required 3", first_pop);
      end
      tests_run++;
      if (exp_q.size() != 0 || hs_count != 2) begin
         tests_failed++;
         $display("[TB] FAIL t2_drain: got left=%0d hs=%0d, required 0 2", exp_q.size(), hs_count);
      end
   endtask

   task automatic test_inflight_limit();
      do_reset();
      dc_req_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) fifo_q.push_back(mk(30 + i));
      for (int i = 0; i < 4; i++) exp_q.push_back(mk_exp(mk(30 + i), 7'(7'h70 + i), 1'b1));
      pf_enable_i = 1'b1;
      repeat (40) step();
      sample();
      tests_run++;
      if (pop_count != 4 || pf_inflight_o !== 3'd4 || fifo_q.size() != 1 || exp_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL t3_limit: got pops=%0d inflight=%0d fifo=%0d left=%0d, required 4 4 1 0",
                  pop_count, pf_inflight_o, fifo_q.size(), exp_q.size());
      end
      step();
      dc_rsp_valid_i = 1'b1;
      dc_rsp_tid_i   = 7'h05;
      step();
      dc_rsp_tid_i   = 7'h74;
      step();
      dc_rsp_valid_i = 1'b0;
      step();
      sample();
      tests_run++;
      if (pf_inflight_o !== 3'd4 || pop_count != 4) begin
         tests_failed++;
         $display("[TB] FAIL t3_ignore_rsp: got inflight=%0d pops=%0d, required 4 4", pf_inflight_o, pop_count);
      end
      step();
      exp_q.push_back(mk_exp(mk(34), 7'h71, 1'b1));
      dc_rsp_valid_i = 1'b1;
      dc_rsp_tid_i   = 7'h71;
      step();
      dc_rsp_valid_i = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      repeat (2) step();
      sample();
      tests_run++;
      if (exp_q.size() != 0 || pop_count != 5 || pf_inflight_o !== 3'd4) begin
         tests_failed++;
         $display("[TB] FAIL t3_reuse: got left=%0d pops=%0d inflight=%0d, required 0 5 4", exp_q.size(), pop_count, pf_inflight_o);
      end
      step();
      pf_enable_i    = 1'b0;
      dc_rsp_valid_i = 1'b1;
      dc_rsp_tid_i   = 7'h72;
      repeat (2) step();
      dc_rsp_valid_i = 1'b0;
      step();
      sample();
      tests_run++;
      if (pf_inflight_o !== 3'd3) begin
         tests_failed++;
         $display("[TB] FAIL t3_double_free: got inflight=%0d, required 3", pf_inflight_o);
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      bad = 0;
      do_reset();
      dc_req_ready_i = 1'b1;
      pf_enable_i    = 1'b1;
      fifo_q.push_back(mk(40));
      for (int k = 0; k < 6; k++) begin
         cpu_req_valid_i = 1'b1;
         cpu_req_i       = mk(50 + k);
         cpu_req_tid_i   = 7'(8 + k);
         exp_q.push_back(mk_exp(mk(50 + k), 7'(8 + k), 1'b0));
         sample();
         tests_run++;
         if (cpu_req_ready_o !== 1'b1 || pf_read_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL t4_accept_%0d: got ready=%b read=%b, required 1 0", k, cpu_req_ready_o, pf_read_o);
         end
         step();
      end
      cpu_req_valid_i = 1'b0;
      exp_q.push_back(mk_exp(mk(40), 7'h70, 1'b1));
      tests_run++;
      if (pop_count != 0) begin
         tests_failed++;
         $display("[TB] FAIL t4_no_pop_in_stream: got pops=%0d, required 0", pop_count);
      end
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
      pf_enable_i = 1'b0;
      tests_run++;
      if (exp_q.size() != 0 || hs_count != 7) begin
         tests_failed++;
         $display("[TB] FAIL t4_drain: got left=%0d hs=%0d, required 0 7", exp_q.size(), hs_count);
      end
   endtask

   task automatic test_flush();
      int seen_valid;
      seen_valid = 0;
      do_reset();
      dc_req_ready_i = 1'b1;
      fifo_q.push_back(mk(60));
      fifo_q.push_back(mk(61));
      exp_q.push_back(mk_exp(mk(60), 7'h70, 1'b1));
      pf_enable_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         sample();
         if (pf_inflight_o === 3'd1) break;
         step();
      end
      tests_run++;
      if (pf_inflight_o !== 3'd1 || pf_read_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL t5_second_pop: got inflight=%0d read=%b, required 1 1", pf_inflight_o, pf_read_o);
      end
      step();
      flush_i = 1'b1;
      sample();
      if (dc_req_valid_o !== 1'b0) seen_valid++;
      step();
      sample();
      tests_run++;
      if (pf_read_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL t5_idle_no_pop: got read=%b, required 0", pf_read_o);
      end
      if (dc_req_valid_o !== 1'b0) seen_valid++;
      step();
      flush_i     = 1'b0;
      pf_enable_i = 1'b0;
      repeat (4) begin
         sample();
         if (dc_req_valid_o !== 1'b0) seen_valid++;
         step();
      end
      tests_run++;
      if (seen_valid != 0 || hs_count != 1 || exp_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL t5_no_request: got valid cycles=%0d hs=%0d left=%0d, required 0 1 0", seen_valid, hs_count, exp_q.size());
      end
      tests_run++;
      if (pf_inflight_o !== 3'd1 || pop_count != 2) begin
         tests_failed++;
         $display("[TB] FAIL t5_inflight_kept: got inflight=%0d pops=%0d, required 1 2", pf_inflight_o, pop_count);
      end
   endtask

   task automatic test_stall_stable();
      do_reset();
      fifo_q.push_back(mk(70));
      exp_q.push_back(mk_exp(mk(70), 7'h70, 1'b1));
      exp_q.push_back(mk_exp(mk(71), 7'h09, 1'b0));
      pf_enable_i = 1'b1;
      step();
      step();
      sample();
      tests_run++;
      if (dc_req_valid_o !== 1'b1 || dc_req_is_pf_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL t6_pf_valid: got valid=%b pf=%b, required 1 1", dc_req_valid_o, dc_req_is_pf_o);
      end
      step();
      pf_enable_i     = 1'b0;
      cpu_req_valid_i = 1'b1;
      cpu_req_i       = mk(71);
      cpu_req_tid_i   = 7'h09;
      sample();
      tests_run++;
      if (cpu_req_ready_o !== 1'b0 || dc_req_tid_o !== 7'h70) begin
         tests_failed++;
         $display("[TB] FAIL t6_stall_c3: got ready=%b tid=%h, required 0 70", cpu_req_ready_o, dc_req_tid_o);
      end
      step();
      sample();
      step();
      dc_req_ready_i = 1'b1;
      sample();
      tests_run++;
      if (cpu_req_ready_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL t6_pf_first: got ready=%b, required 0", cpu_req_ready_o);
      end
      step();
      sample();
      tests_run++;
      if (cpu_req_ready_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL t6_demand_after: got ready=%b, required 1", cpu_req_ready_o);
      end
      step();
      cpu_req_valid_i = 1'b0;
      step();
      sample();
      tests_run++;
      if (exp_q.size() != 0 || pf_inflight_o !== 3'd1) begin
         tests_failed++;
         $display("[TB] FAIL t6_drain: got left=%0d inflight=%0d, required 0 1", exp_q.size(), pf_inflight_o);
      end
   endtask

   task automatic checkOutput_summary();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
   endtask

   initial begin
      tests_run       = 0;
      tests_failed    = 0;
      pop_count       = 0;
      hs_count        = 0;
      stalled         = 1'b0;
      pf_req_valid_i  = 1'b0;
      pf_req_i        = '0;
      applyStimulus_idle();
      rst_ni = 1'b1;
      #3;
      test_reset();
      test_first_prefetch();
      test_demand_priority();
      test_inflight_limit();
      test_back_to_back();
      test_flush();
      test_stall_stable();
      checkOutput_summary();
      $finish;
   end

endmodule
